segment_sequencer: RTL

//  Parametrised multi-segment count sequencer: one counter steps through NUM_SEG chained segments.

---
 rtl/segment_sequencer_pkg.sv | 33 +++
 rtl/segment_sequencer_if.sv | 31 +++
 rtl/segment_sequencer_tick_prescaler.sv | 36 +++
 rtl/segment_sequencer.sv | 132 +++++++++++++
 4 files changed

// File: rtl/segment_sequencer_pkg.sv
// Shared definitions for the segment sequencer.
//   seq_state_e : FSM state encoding (IDLE, RUN, PAUSE, DONE)
//   seg_field() : pulls field i of width w out of a packed parameter table
package segment_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

  // Upper bounds for packed tables handed to seg_field(); a table of
  // NUM_SEG*WIDTH bits must fit in TABLE_MAX and WIDTH in FIELD_MAX.
  localparam int TABLE_MAX = 1024;
  localparam int FIELD_MAX = 32;

  function automatic logic [FIELD_MAX-1:0] seg_field(
    input logic [TABLE_MAX-1:0] vec,
    input int                   i,
    input int                   w
  );
    logic [TABLE_MAX-1:0] sh;
    logic [FIELD_MAX-1:0] f;
    sh = vec >> (i * w);
    f  = '0;
    for (int b = 0; b < FIELD_MAX; b++) begin
      if (b < w) f[b] = sh[b];
    end
    return f;
  endfunction

endpackage

// File: rtl/segment_sequencer_if.sv
// Control/status bundle between the sequencer and its user.
//   go, pause          : user -> sequencer
//   count, seg_idx,    : sequencer -> user, all registered
//   seg_last, busy,
//   done, dbg_state
// Handshake: go is a plain request sampled on every clk edge; there is no
// ready. It is acted on only in IDLE or DONE and silently dropped in RUN or
// PAUSE. pause is a level, honoured only in RUN/PAUSE.
interface segment_sequencer_if #(
  parameter int WIDTH = 4,
  parameter int IDX_W = 1
);
  logic                              go;
  logic                              pause;
  logic [WIDTH-1:0]                  count;
  logic [IDX_W-1:0]                  seg_idx;
  logic                              seg_last;
  logic                              busy;
  logic                              done;
  segment_sequencer_pkg::seq_state_e dbg_state;

  modport master (
    output go, pause,
    input  count, seg_idx, seg_last, busy, done, dbg_state
  );

  modport slave (
    input  go, pause,
    output count, seg_idx, seg_last, busy, done, dbg_state
  );
endinterface

// File: rtl/segment_sequencer_tick_prescaler.sv
// Step-rate prescaler: one tick every PRESCALE enabled clocks.
//   clk, rst_btn : clock, asynchronous active-low reset
//   en           : count enable (sequencer running and not paused)
//   clr          : restart the period from zero (sequencer start edge)
//   tick         : combinational, high while the count sits at PRESCALE-1
//                  and en is high
module segment_sequencer_tick_prescaler #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic rst_btn,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == PS_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + PS_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_btn) begin
    if (!rst_btn) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
endmodule

// File: rtl/segment_sequencer.sv
// Multi-segment count sequencer. One counter walks NUM_SEG chained segments,
// each with its own start, end and increment; loops or stops in DONE.
//   clk, rst_btn : clock, asynchronous active-low reset
//   bus (slave)  : go/pause in; count, seg_idx, seg_last, busy, done and
//                  dbg_state (current FSM state) out, all registered
module segment_sequencer
  import segment_sequencer_pkg::*;
#(
  parameter int                         WIDTH      = 4,
  parameter int                         NUM_SEG    = 2,
  parameter logic [NUM_SEG*WIDTH-1:0]   SEG_START  = {4'd14, 4'd0},
  parameter logic [NUM_SEG*WIDTH-1:0]   SEG_END    = {4'd1, 4'd15},
  parameter logic [NUM_SEG*WIDTH-1:0]   SEG_INCR   = {4'hF, 4'd1},
  parameter bit                         LOOP       = 1'b1,
  parameter bit                         AUTO_START = 1'b1,
  parameter int unsigned                PRESCALE   = 12_000_000
) (
  input logic                clk,
  input logic                rst_btn,
  segment_sequencer_if.slave bus
);
  localparam int IDX_W = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1;
  localparam logic [IDX_W-1:0] LAST_SEG = IDX_W'(NUM_SEG - 1);

  // Per-segment constants unpacked once so the datapath is a plain mux.
  logic [WIDTH-1:0] start_tab [NUM_SEG];
  logic [WIDTH-1:0] end_tab   [NUM_SEG];
  logic [WIDTH-1:0] incr_tab  [NUM_SEG];

  for (genvar g = 0; g < NUM_SEG; g++) begin : g_tab
    assign start_tab[g] = WIDTH'(seg_field(TABLE_MAX'(SEG_START), g, WIDTH));
    assign end_tab[g]   = WIDTH'(seg_field(TABLE_MAX'(SEG_END),   g, WIDTH));
    assign incr_tab[g]  = WIDTH'(seg_field(TABLE_MAX'(SEG_INCR),  g, WIDTH));
  end

  seq_state_e       state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [IDX_W-1:0] seg_q, seg_d;
  logic             seg_last_q, seg_last_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             start;
  logic             tick;
  logic             ps_en;

  // The prescaler only advances in RUN with pause low. The clock spent in
  // PAUSE that sees pause drop is also frozen, so the period picks up where
  // it stopped on the first clock back in RUN.
  assign ps_en = (state_q == ST_RUN) && !bus.pause;

  segment_sequencer_tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk     (clk),
    .rst_btn (rst_btn),
    .en      (ps_en),
    .clr     (start),
    .tick    (tick)
  );

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    seg_d      = seg_q;
    seg_last_d = 1'b0;
    start      = 1'b0;

    case (state_q)
      ST_IDLE:  if (bus.go || AUTO_START) start = 1'b1;
      ST_RUN: begin
        if (bus.pause) begin
          state_d = ST_PAUSE;
        end else if (tick) begin
          if (count_q != end_tab[seg_q]) begin
            count_d = count_q + incr_tab[seg_q];
          end else begin
            seg_last_d = 1'b1;
            if (seg_q != LAST_SEG) begin
              seg_d   = seg_q + IDX_W'(1);
              count_d = start_tab[seg_q + IDX_W'(1)];
            end else if (LOOP) begin
              seg_d   = '0;
              count_d = start_tab[0];
            end else begin
              // One-shot: park on the final END value.
              state_d = ST_DONE;
            end
          end
        end
      end
      ST_PAUSE: if (!bus.pause) state_d = ST_RUN;
      ST_DONE:  if (bus.go) start = 1'b1;
      default:  state_d = ST_IDLE;
    endcase

    // A start never takes a step in the same clock; the prescaler is cleared
    // alongside so the first step lands PRESCALE clocks later.
    if (start) begin
      state_d = ST_RUN;
      count_d = start_tab[0];
      seg_d   = '0;
    end

    busy_d = (state_d == ST_RUN) || (state_d == ST_PAUSE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_btn) begin
    if (!rst_btn) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      seg_q      <= '0;
      seg_last_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      seg_q      <= seg_d;
      seg_last_q <= seg_last_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.count     = count_q;
  assign bus.seg_idx   = seg_q;
  assign bus.seg_last  = seg_last_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.dbg_state = state_q;
endmodule
